// File: rtl/instr_sequencer.sv
// Instruction issue unit: loadable program buffer, program counter and an
// issue FSM that hands words to the processor over its done handshake.
module instr_sequencer #(
  parameter int OP_W    = 3,
  parameter int RA_W    = 5,
  parameter int CONST_W = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_en,
  input  logic [ADDR_W-1:0]                load_addr,
  input  logic [OP_W+3*RA_W+CONST_W-1:0]   load_word,
  input  logic [ADDR_W:0]                  prog_len,
  input  logic                             start,
  input  logic                             step_mode,
  input  logic                             step,
  input  logic                             done,
  output logic [OP_W-1:0]                  instr,
  output logic [RA_W-1:0]                  reg1,
  output logic [RA_W-1:0]                  reg2,
  output logic [RA_W-1:0]                  reg3,
  // "const" is a reserved word, so the immediate output is const_val
  output logic [CONST_W-1:0]               const_val,
  output logic                             issue,
  output logic                             busy,
  output logic                             finished,
  output logic [ADDR_W:0]                  pc
);

  localparam int WORD_W = OP_W + 3*RA_W + CONST_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    STEP_WAIT,
    HALT
  } state_t;

  state_t              state;
  logic [ADDR_W:0]     len;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   word_rd;
  logic                can_accept;

  assign can_accept = (state == IDLE) || (state == HALT);
  assign word_rd    = mem[pc[ADDR_W-1:0]];

  // Program buffer is not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && load_en && can_accept)
      mem[load_addr] <= load_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      pc        <= '0;
      instr     <= '0;
      reg1      <= '0;
      reg2      <= '0;
      reg3      <= '0;
      const_val <= '0;
      issue     <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
    end else begin
      issue <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            len <= prog_len;
            pc  <= '0;
            if (prog_len == '0) begin
              state    <= HALT;
              finished <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state    <= ISSUE;
              finished <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (done) begin
            {instr, reg1, reg2, reg3, const_val} <= word_rd;
            issue <= 1'b1;
            pc    <= pc + 1'b1;
            state <= WAIT_LOW;
          end
        end
        // done must fall before we look for completion, so a slow processor
        // that still shows done=1 after issue cannot trigger a second issue.
        WAIT_LOW: begin
          if (!done)
            state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (done) begin
            if (pc == len) begin
              state    <= HALT;
              finished <= 1'b1;
              busy     <= 1'b0;
            end else if (step_mode) begin
              state <= STEP_WAIT;
            end else begin
              state <= ISSUE;
            end
          end
        end
        STEP_WAIT: begin
          if (step || !step_mode)
            state <= ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected issue stream is derived from a
// shadow copy of the program buffer; a monitor compares every issued word.
module tb_instr_sequencer;

  localparam int OP_W    = 3;
  localparam int RA_W    = 5;
  localparam int CONST_W = 16;
  localparam int ADDR_W  = 4;
  localparam int WORD_W  = OP_W + 3*RA_W + CONST_W;
  localparam int DEPTH   = 1 << ADDR_W;

  logic                 clk;
  logic                 rst;
  logic                 load_en;
  logic [ADDR_W-1:0]    load_addr;
  logic [WORD_W-1:0]    load_word;
  logic [ADDR_W:0]      prog_len;
  logic                 start;
  logic                 step_mode;
  logic                 step;
  logic                 done;
  logic [OP_W-1:0]      instr;
  logic [RA_W-1:0]      reg1;
  logic [RA_W-1:0]      reg2;
  logic [RA_W-1:0]      reg3;
  logic [CONST_W-1:0]   const_val;
  logic                 issue;
  logic                 busy;
  logic                 finished;
  logic [ADDR_W:0]      pc;

  instr_sequencer #(
    .OP_W(OP_W), .RA_W(RA_W), .CONST_W(CONST_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_word(load_word), .prog_len(prog_len), .start(start),
    .step_mode(step_mode), .step(step), .done(done), .instr(instr),
    .reg1(reg1), .reg2(reg2), .reg3(reg3), .const_val(const_val),
    .issue(issue), .busy(busy), .finished(finished), .pc(pc)
  );

  int                vectors = 0;
  int                miscompares = 0;
  int                n_issue = 0;
  logic [WORD_W-1:0] mem_m [DEPTH];
  logic [WORD_W-1:0] expq [$];
  bit                proc_auto = 1'b1;
  bit                done_force = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WORD_W-1:0] mk(input int op, input int r1, input int r2,
                                           input int r3, input int c);
    return {op[OP_W-1:0], r1[RA_W-1:0], r2[RA_W-1:0], r3[RA_W-1:0], c[CONST_W-1:0]};
  endfunction

  // Processor model: done falls one cycle after an issue and rises three later.
  initial begin
    done = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!proc_auto) begin
        done = done_force;
      end else if (issue) begin
        @(posedge clk);
        #2;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        done = 1'b1;
      end
    end
  end

  // Monitor: every issue pulse must match the next expected word.
  always @(negedge clk) begin
    if (issue === 1'b1) begin
      n_issue++;
      if (expq.size() == 0) begin
        chk("unexpected_issue", {30'd0, instr, reg1, reg2, reg3, const_val}, 64'hDEAD);
      end else begin
        chk("issue_word", {30'd0, instr, reg1, reg2, reg3, const_val}, {30'd0, expq.pop_front()});
      end
    end
  end

  task automatic load(input int addr, input logic [WORD_W-1:0] w, input bit accepted);
    load_en   = 1'b1;
    load_addr = addr[ADDR_W-1:0];
    load_word = w;
    tick();
    load_en = 1'b0;
    if (accepted) mem_m[addr] = w;
  endtask

  task automatic run_start(input int len, input bit sm);
    prog_len  = len[ADDR_W:0];
    step_mode = sm;
    start     = 1'b1;
    for (int i = 0; i < len; i++) expq.push_back(mem_m[i]);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_finished(input string name, input int len);
    int n = 0;
    while (finished !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_finished"}, finished, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_pc"}, pc, len);
    chk({name, "_drained"}, expq.size(), 0);
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    while (issue !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_seen"}, issue, 1);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {22'd0, instr, reg1, reg2, reg3, const_val, issue, busy, finished, pc}, 0);
  endtask

  initial begin
    int base;
    int len;
    logic [WORD_W-1:0] w;

    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_word = '0; prog_len = '0;
    start = 1'b0; step_mode = 1'b0; step = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    tick();
    tick();
    chk_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // Nine-word program in free-run mode.
    load(0, mk(0, 0, 0, 1, 17), 1);
    load(1, mk(3, 1, 0, 2, -9), 1);
    load(2, mk(4, 1, 2, 3, 65), 1);
    load(3, mk(2, 2, 3, 0, 0), 1);
    load(4, mk(7, 3, 0, 5, 3), 1);
    load(5, mk(5, 1, 2, 4, 0), 1);
    load(6, mk(7, 4, 0, 4, 9), 1);
    load(7, mk(6, 5, 4, 6, 0), 1);
    load(8, mk(1, 6, 0, 0, 0), 1);
    chk("word1_const", mem_m[1][CONST_W-1:0], 16'hFFF7);
    base = n_issue;
    run_start(9, 0);
    chk("run9_busy", busy, 1);
    wait_finished("run9", 9);
    chk("run9_count", n_issue - base, 9);

    // Zero-length run.
    base = n_issue;
    run_start(0, 0);
    chk("len0_finished", finished, 1);
    chk("len0_busy", busy, 0);
    chk("len0_pc", pc, 0);
    repeat (5) tick();
    chk("len0_no_issue", n_issue - base, 0);

    // Single-step mode.
    base = n_issue;
    run_start(3, 1);
    wait_issue("step_first");
    tick();
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (10) tick();
    chk("step_ignored", n_issue - base, 1);
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_early", issue, 0);
      tick();
      chk("step_issue", issue, 1);
      repeat (10) tick();
      chk("step_count", n_issue - base, k + 2);
    end
    wait_finished("step3", 3);
    step_mode = 1'b0;

    // done stuck high after issue: no second issue until it dips.
    done_force = 1'b1;
    proc_auto  = 1'b0;
    tick();
    base = n_issue;
    run_start(3, 0);
    wait_issue("stuck_first");
    repeat (10) tick();
    chk("stuck_hold", n_issue - base, 1);
    done_force = 1'b0;
    tick();
    done_force = 1'b1;
    repeat (10) tick();
    chk("stuck_one_more", n_issue - base, 2);
    rst = 1'b1;
    tick();
    chk_zero("stuck_rst_outputs");
    rst = 1'b0;
    expq.delete();
    proc_auto = 1'b1;
    tick();

    // Load during a run is dropped; rst aborts; restart uses retained buffer.
    base = n_issue;
    run_start(9, 0);
    load(2, mk(6, 31, 31, 31, 16'h1234), 0);
    while (n_issue - base < 4 && busy === 1'b1) tick();
    rst = 1'b1;
    tick();
    chk_zero("midrun_rst_outputs");
    rst = 1'b0;
    expq.delete();
    base = n_issue;
    repeat (12) tick();
    chk("midrun_no_issue", n_issue - base, 0);
    run_start(9, 0);
    wait_finished("restart", 9);
    chk("restart_count", n_issue - base, 9);

    // Full-depth program; word 0 written in the same cycle as start.
    for (int i = 1; i < DEPTH; i++) load(i, WORD_W'({$urandom, $urandom}), 1);
    w = WORD_W'({$urandom, $urandom});
    load_en   = 1'b1;
    load_addr = '0;
    load_word = w;
    mem_m[0]  = w;
    base = n_issue;
    run_start(DEPTH, 0);
    load_en = 1'b0;
    wait_finished("full", DEPTH);
    chk("full_count", n_issue - base, DEPTH);

    // Randomized reloads and run lengths.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++)
        load($urandom_range(0, DEPTH - 1), WORD_W'({$urandom, $urandom}), 1);
      len  = $urandom_range(1, DEPTH);
      base = n_issue;
      run_start(len, 0);
      if ($urandom_range(0, 1) == 1) load($urandom_range(0, DEPTH - 1), '1, 0);
      wait_finished("rand", len);
      chk("rand_count", n_issue - base, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
